// File: rtl/sram_stream_reader_if.sv
// ---------------------------------------------------------------------------
// sram_stream_reader_if
// Bundles the three signal groups of the SRAM stream reader:
//   control : start, base_addr, length (in); busy, done (out)
//   sram    : sram_wea, sram_addr, sram_wdata (out); sram_rdata (in)
//   stream  : m_valid, m_data, m_last (out); m_ready (in)
// The master modport is the reader itself; the slave modport is whatever
// drives control, models the SRAM and consumes the stream.
// ---------------------------------------------------------------------------
interface sram_stream_reader_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] length;
   logic              busy;
   logic              done;

   logic [3:0]        sram_wea;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;

   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;

   modport master (
      input  start, base_addr, length, sram_rdata, m_ready,
      output busy, done, sram_wea, sram_addr, sram_wdata, m_valid, m_data, m_last
   );

   modport slave (
      output start, base_addr, length, sram_rdata, m_ready,
      input  busy, done, sram_wea, sram_addr, sram_wdata, m_valid, m_data, m_last
   );
endinterface

// File: rtl/sram_stream_reader.sv
// ---------------------------------------------------------------------------
// sram_stream_reader
// Reads `length` words from a circular SRAM address space of DEPTH words,
// starting at `base_addr`, and delivers them on a valid/ready stream with
// m_last on the final beat. Reads are issued one per cycle through a
// registered address; data returns one cycle later and is captured into a
// 4-entry FIFO whose head drives the stream.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sram_stream_reader_if.master (control, SRAM port, stream)
// ---------------------------------------------------------------------------
module sram_stream_reader #(
   parameter int DEPTH  = 480,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   sram_stream_reader_if.master bus
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;        // registered SRAM read address
   logic [ADDR_W-1:0] iss_left_q;    // reads still to issue after the current one
   logic [ADDR_W-1:0] beats_left_q;  // beats still to deliver, including the head
   logic              issue_q;       // addr_q holds a newly issued read this cycle
   logic              pend_q;        // read data on sram_rdata to capture this cycle

   logic [DATA_W-1:0] fifo_q [4];
   logic [1:0]        wr_ptr_q;
   logic [1:0]        rd_ptr_q;
   logic [2:0]        count_q;

   logic              push;
   logic              pop;
   logic              can_issue;
   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] addr_next;

   assign push = pend_q;
   assign pop  = (count_q != 3'd0) && bus.m_ready;

   // Circular wrap by compare-and-subtract: one past the top returns to 0.
   assign addr_inc  = addr_q + ADDR_W'(1);
   assign addr_next = (addr_inc == ADDR_W'(DEPTH)) ? addr_inc - ADDR_W'(DEPTH) : addr_inc;

   // The read currently on addr_q is not counted: at most two more words can
   // land (pend + current) plus this new one, so count+pend <= 2 bounds the
   // FIFO at four entries even if the consumer stalls indefinitely.
   assign can_issue = (state_q == RUN) && (iss_left_q != '0) &&
                      ((int'(count_q) + int'(pend_q)) <= 2);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         iss_left_q   <= '0;
         beats_left_q <= '0;
         issue_q      <= 1'b0;
         pend_q       <= 1'b0;
      end else begin
         pend_q  <= issue_q;
         issue_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (bus.length == '0) begin
                     state_q <= FINISH;
                  end else begin
                     state_q      <= RUN;
                     addr_q       <= bus.base_addr;
                     issue_q      <= 1'b1;
                     iss_left_q   <= bus.length - ADDR_W'(1);
                     beats_left_q <= bus.length;
                  end
               end
            end
            RUN: begin
               if (can_issue) begin
                  addr_q     <= addr_next;
                  issue_q    <= 1'b1;
                  iss_left_q <= iss_left_q - ADDR_W'(1);
               end
               if (pop) begin
                  beats_left_q <= beats_left_q - ADDR_W'(1);
                  if (beats_left_q == ADDR_W'(1)) state_q <= FINISH;
               end
            end
            FINISH:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // NOTE: the FIFO storage is reset too; it is only four words and a reset
   // head keeps m_data at zero while the FIFO is empty after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= bus.sram_rdata;
            wr_ptr_q         <= wr_ptr_q + 2'd1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 3'd1;
            2'b01:   count_q <= count_q - 3'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.busy       = (state_q != IDLE);
   assign bus.done       = (state_q == FINISH);
   assign bus.sram_wea   = 4'b0000;
   assign bus.sram_addr  = addr_q;
   assign bus.sram_wdata = '0;
   assign bus.m_valid    = (count_q != 3'd0);
   assign bus.m_data     = fifo_q[rd_ptr_q];
   assign bus.m_last     = (state_q == RUN) && (count_q != 3'd0) &&
                           (beats_left_q == ADDR_W'(1));

endmodule

// File: tb/tb_sram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_sram_stream_reader
// Directed bench for sram_stream_reader. SRAM word k holds 0xA000_0000 + k.
// Cycle 0 is the cycle in which start is driven; inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_sram_stream_reader;

   localparam int DEPTH  = 480;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;

   logic clk;
   logic rst_n;

   sram_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sram_stream_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read SRAM model: data for the address seen at an edge is
   // valid throughout the following cycle.
   logic [DATA_W-1:0] sram_mem [DEPTH];
   initial for (int k = 0; k < DEPTH; k++) sram_mem[k] = 32'hA000_0000 + k;
   always @(posedge clk) bus.sram_rdata <= sram_mem[bus.sram_addr];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Per-burst observations.
   logic [DATA_W-1:0] data_q [$];
   int                cyc_q  [$];
   bit                last_q [$];
   int                done_cyc;
   int                stall_err;
   int                valid_cycles;
   int                addr_changes;
   bit                busy1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse start in cycle 0 and run until done (bounded). bp selects the
   // 1,0,0,1 m_ready pattern; mid pulses a second start in cycle 3.
   task automatic run_burst(input int base, input int len, input bit bp, input bit mid);
      bit                stalled = 1'b0;
      logic [DATA_W-1:0] held    = '0;
      logic [ADDR_W-1:0] a0;
      data_q.delete(); cyc_q.delete(); last_q.delete();
      done_cyc = -1; stall_err = 0; valid_cycles = 0; addr_changes = 0; busy1 = 1'b0;
      a0 = bus.sram_addr;
      for (int c = 0; c < 2000; c++) begin
         bus.start     = (c == 0) || (mid && c == 3);
         bus.base_addr = (c == 0) ? base[ADDR_W-1:0] : '0;
         bus.length    = (c == 0) ? len[ADDR_W-1:0]  : ADDR_W'(2);
         bus.m_ready   = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
         if (c == 1) busy1 = bus.busy;
         if (bus.sram_addr != a0) addr_changes++;
         if (stalled && (!bus.m_valid || bus.m_data != held)) stall_err++;
         if (bus.m_valid) valid_cycles++;
         stalled = bus.m_valid && !bus.m_ready;
         held    = bus.m_data;
         if (bus.m_valid && bus.m_ready) begin
            data_q.push_back(bus.m_data);
            cyc_q.push_back(c);
            last_q.push_back(bus.m_last);
         end
         if (bus.done) begin
            done_cyc = c;
            break;
         end
         step();
      end
      bus.start = 1'b0;
      if (done_cyc < 0) check("timeout_done", 64'd1, 64'd0);
      step();  // FINISH -> IDLE
   endtask

   // Delivered words must be (base+i) mod DEPTH in order, m_last on the final one only.
   task automatic check_beats(input string tag, input int base, input int len);
      int data_err = 0;
      int last_err = 0;
      check({tag, "_beats"}, data_q.size(), len);
      for (int i = 0; i < data_q.size(); i++) begin
         if (data_q[i] !== 32'hA000_0000 + ((base + i) % DEPTH)) data_err++;
         if (last_q[i] !== (i == len - 1)) last_err++;
      end
      check({tag, "_data_err"}, data_err, 0);
      check({tag, "_last_err"}, last_err, 0);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.length    = '0;
      bus.m_ready   = 1'b1;
      #1;
      check("rst_busy",   bus.busy,       0);
      check("rst_done",   bus.done,       0);
      check("rst_valid",  bus.m_valid,    0);
      check("rst_last",   bus.m_last,     0);
      check("rst_mdata",  bus.m_data,     0);
      check("rst_addr",   bus.sram_addr,  0);
      check("rst_wea",    bus.sram_wea,   0);
      check("rst_wdata",  bus.sram_wdata, 0);
      step(); step();
      rst_n = 1'b1;

      // Basic burst: beats in cycles 3..6, done in cycle 7.
      run_burst(0, 4, 1'b0, 1'b0);
      check_beats("basic", 0, 4);
      check("basic_busy1", busy1, 1);
      if (cyc_q.size() == 4) begin
         check("basic_cyc0", cyc_q[0], 3);
         check("basic_cyc3", cyc_q[3], 6);
      end
      check("basic_done_cyc", done_cyc, 7);

      // Wrap-around: 478, 479, 0, 1.
      run_burst(478, 4, 1'b0, 1'b0);
      check_beats("wrap", 478, 4);
      if (data_q.size() == 4) check("wrap_beat2", data_q[2], 32'hA000_0000);

      // Backpressure with m_ready 1,0,0,1.
      run_burst(100, 8, 1'b1, 1'b0);
      check_beats("bp", 100, 8);
      check("bp_stable", stall_err, 0);

      // Zero length: no issue, no valid, done in cycle 1; sram_addr holds 107.
      run_burst(5, 0, 1'b0, 1'b0);
      check("zero_beats",   data_q.size(), 0);
      check("zero_valid",   valid_cycles,  0);
      check("zero_addr_ch", addr_changes,  0);
      check("zero_addr",    bus.sram_addr, 107);
      check("zero_done",    done_cyc,      1);

      // Start pulsed mid-burst is ignored.
      run_burst(20, 6, 1'b0, 1'b1);
      check_beats("midstart", 20, 6);
      check("midstart_done", done_cyc, 9);

      // Reset in cycle 5 of a 16-word burst.
      bus.start = 1'b1; bus.base_addr = '0; bus.length = ADDR_W'(16); bus.m_ready = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (4) step();
      check("pre_rst_busy", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy",  bus.busy,      0);
      check("mid_rst_done",  bus.done,      0);
      check("mid_rst_valid", bus.m_valid,   0);
      check("mid_rst_last",  bus.m_last,    0);
      check("mid_rst_mdata", bus.m_data,    0);
      check("mid_rst_addr",  bus.sram_addr, 0);
      step();
      rst_n = 1'b1;
      run_burst(10, 2, 1'b0, 1'b0);
      check_beats("post_rst", 10, 2);
      if (cyc_q.size() == 2) check("post_rst_cyc0", cyc_q[0], 3);
      check("post_rst_done", done_cyc, 5);

      // Full 480-word burst, back to back.
      run_burst(0, 480, 1'b0, 1'b0);
      check_beats("full", 0, 480);
      if (cyc_q.size() == 480) begin
         check("full_first", cyc_q[0],   3);
         check("full_span",  cyc_q[479] - cyc_q[0], 479);
      end
      check("full_done", done_cyc, 483);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
